// File: rtl/obi_mem_tester.sv
// obi_mem_tester: at-speed OBI write/read-back memory tester.
// Each iteration writes a pseudo-random word to a pseudo-random aligned address inside a
// power-of-two window and reads it back. Mismatches and bus errors are counted (saturating),
// and a stalled handshake aborts the test with timeout_o.
// Optional feature: define OBI_MEM_TESTER_ERRLOG_EN to add first-failure capture outputs
// (fail_addr_o, fail_exp_o, fail_rdata_o, fail_vld_o).
module obi_mem_tester #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned IterWidth     = 16,
  parameter int unsigned ErrCntWidth   = 16,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [AddrWidth-1:0]   base_addr_i,
  input  logic [5:0]             size_log2_i,
  input  logic [IterWidth-1:0]   iter_i,
  input  logic [31:0]            seed_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   timeout_o,
  output logic [ErrCntWidth-1:0] err_cnt_o,
  output logic                   req_o,
  input  logic                   gnt_i,
  output logic [AddrWidth-1:0]   addr_o,
  output logic                   we_o,
  output logic [DataWidth/8-1:0] be_o,
  output logic [DataWidth-1:0]   wdata_o,
  input  logic                   rvalid_i,
  input  logic [DataWidth-1:0]   rdata_i,
  input  logic                   err_i
`ifdef OBI_MEM_TESTER_ERRLOG_EN
  ,
  output logic [AddrWidth-1:0]   fail_addr_o,
  output logic [DataWidth-1:0]   fail_exp_o,
  output logic [DataWidth-1:0]   fail_rdata_o,
  output logic                   fail_vld_o
`endif
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned TmoWidth = $clog2(TimeoutCycles);
  localparam logic [TmoWidth-1:0]  TmoLast   = TmoWidth'(TimeoutCycles - 1);
  localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(BeWidth - 1);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, NEXT, DONE
  } state_e;

  state_e               state;
  logic [31:0]          lfsr;
  logic [AddrWidth-1:0] base_q;
  logic [AddrWidth-1:0] mask_q;
  logic [IterWidth-1:0] iter_cnt;
  logic [TmoWidth-1:0]  tmo_cnt;

  logic                 start_ok;
  logic [31:0]          seed_eff;
  logic [31:0]          lfsr_src;
  logic [31:0]          rnd_a;
  logic [31:0]          rnd_d;
  logic [AddrWidth-1:0] base_sel;
  logic [AddrWidth-1:0] mask_sel;
  logic [AddrWidth-1:0] addr_nxt;
  logic [DataWidth-1:0] wdata_nxt;
  logic                 in_wait;
  logic                 progress;
  logic                 abort;
  logic                 err_sat;
  logic                 rd_bad;

  function automatic logic [31:0] xs32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // On a start the next address/data derive from the new seed and window, otherwise from
  // the running LFSR and the latched window.
  assign start_ok  = start_i && (state == IDLE || state == DONE);
  assign seed_eff  = (seed_i == 32'h0) ? 32'h1 : seed_i;
  assign lfsr_src  = start_ok ? seed_eff : lfsr;
  assign rnd_a     = xs32(lfsr_src);
  assign rnd_d     = xs32(rnd_a);
  assign base_sel  = start_ok ? base_addr_i : base_q;
  assign mask_sel  = start_ok ? ~({AddrWidth{1'b1}} << size_log2_i) : mask_q;
  assign addr_nxt  = base_sel | (AddrWidth'(rnd_a) & mask_sel & AlignMask);
  assign wdata_nxt = {(DataWidth/32){rnd_d}};
  assign be_o      = '1;

  assign in_wait  = (state == WR_REQ) || (state == WR_RSP) || (state == RD_REQ) || (state == RD_RSP);
  assign progress = ((state == WR_REQ || state == RD_REQ) && gnt_i) ||
                    ((state == WR_RSP || state == RD_RSP) && rvalid_i);
  assign abort    = in_wait && !progress && (tmo_cnt == TmoLast);
  assign err_sat  = &err_cnt_o;
  assign rd_bad   = (rdata_i != wdata_o) || err_i;

  // Wait-cycle counter: restarts on every state change, frozen outside handshake states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (!in_wait || progress) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TmoLast) begin
      tmo_cnt <= tmo_cnt + TmoWidth'(1);
    end
  end

  // Main sequencer: all bus and status outputs are registered here.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= 32'h1;
      base_q    <= '0;
      mask_q    <= '0;
      iter_cnt  <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      pass_o    <= 1'b0;
      timeout_o <= 1'b0;
      err_cnt_o <= '0;
      req_o     <= 1'b0;
      we_o      <= 1'b0;
      addr_o    <= '0;
      wdata_o   <= '0;
    end else if (abort) begin
      state     <= DONE;
      req_o     <= 1'b0;
      we_o      <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b1;
      pass_o    <= 1'b0;
      timeout_o <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            base_q    <= base_addr_i;
            mask_q    <= mask_sel;
            iter_cnt  <= iter_i;
            err_cnt_o <= '0;
            timeout_o <= 1'b0;
            if (iter_i == '0) begin
              state  <= DONE;
              lfsr   <= seed_eff;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              pass_o <= 1'b1;
            end else begin
              state   <= WR_REQ;
              lfsr    <= rnd_d;
              busy_o  <= 1'b1;
              done_o  <= 1'b0;
              pass_o  <= 1'b0;
              req_o   <= 1'b1;
              we_o    <= 1'b1;
              addr_o  <= addr_nxt;
              wdata_o <= wdata_nxt;
            end
          end
        end
        WR_REQ: begin
          if (gnt_i) begin
            state <= WR_RSP;
            req_o <= 1'b0;
          end
        end
        WR_RSP: begin
          if (rvalid_i) begin
            if (err_i && !err_sat) err_cnt_o <= err_cnt_o + ErrCntWidth'(1);
            state <= RD_REQ;
            req_o <= 1'b1;
            we_o  <= 1'b0;
          end
        end
        RD_REQ: begin
          if (gnt_i) begin
            state <= RD_RSP;
            req_o <= 1'b0;
          end
        end
        RD_RSP: begin
          if (rvalid_i) begin
            if (rd_bad && !err_sat) err_cnt_o <= err_cnt_o + ErrCntWidth'(1);
            state <= NEXT;
          end
        end
        NEXT: begin
          iter_cnt <= iter_cnt - IterWidth'(1);
          if (iter_cnt == IterWidth'(1)) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            pass_o <= (err_cnt_o == '0) && !timeout_o;
          end else begin
            state   <= WR_REQ;
            lfsr    <= rnd_d;
            req_o   <= 1'b1;
            we_o    <= 1'b1;
            addr_o  <= addr_nxt;
            wdata_o <= wdata_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OBI_MEM_TESTER_ERRLOG_EN
  logic capture;
  assign capture = !fail_vld_o && rvalid_i &&
                   ((state == WR_RSP && err_i) || (state == RD_RSP && rd_bad));

  // First-failure log: cleared by reset or an accepted start, then frozen after one capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_addr_o  <= '0;
      fail_exp_o   <= '0;
      fail_rdata_o <= '0;
      fail_vld_o   <= 1'b0;
    end else if (start_ok) begin
      fail_addr_o  <= '0;
      fail_exp_o   <= '0;
      fail_rdata_o <= '0;
      fail_vld_o   <= 1'b0;
    end else if (capture) begin
      fail_addr_o  <= addr_o;
      fail_exp_o   <= wdata_o;
      fail_rdata_o <= rdata_i;
      fail_vld_o   <= 1'b1;
    end
  end
`endif

endmodule
